// File: rtl/zoe_digit_sequencer.sv
// zoe_digit_sequencer: drives the 4-bit digit code for the 7-segment decoder.
// The digit advances from a free-running prescaler while RUNNING, or once per
// synchronized step-button press while PAUSED. It also supports up/down counting
// and a synchronous, clamped load.
module zoe_digit_sequencer #(
  parameter int MAX_COUNT   = 1000,
  parameter int DIGIT_MAX   = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_en,
  input  logic       step_req,
  input  logic       load_req,
  input  logic       dir,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       tick,
  output logic       wrap,
  output logic       running
);

  localparam int              PW         = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(MAX_COUNT - 1);
  localparam logic [3:0]      DIGIT_TOP  = 4'(DIGIT_MAX);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } mode_t;

  mode_t                  state_reg, state_next;
  logic [SYNC_STAGES-1:0] run_sync_reg;
  logic [SYNC_STAGES-1:0] step_sync_reg;
  logic [SYNC_STAGES-1:0] load_sync_reg;
  logic                   step_hist_reg;
  logic                   load_hist_reg;
  logic                   run_synced;
  logic                   step_evt;
  logic                   load_evt;
  logic                   advance;
  logic [PW-1:0]          presc_reg, presc_next;
  logic [3:0]             digit_reg, digit_next;
  logic                   tick_reg, tick_next;
  logic                   wrap_reg, wrap_next;

  // Input synchronizers plus edge-history flops. Button chains reset to 1 so a
  // button held through reset does not look like a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_sync_reg  <= '0;
      step_sync_reg <= '1;
      load_sync_reg <= '1;
      step_hist_reg <= 1'b1;
      load_hist_reg <= 1'b1;
    end else begin
      run_sync_reg  <= {run_sync_reg[SYNC_STAGES-2:0], run_en};
      step_sync_reg <= {step_sync_reg[SYNC_STAGES-2:0], step_req};
      load_sync_reg <= {load_sync_reg[SYNC_STAGES-2:0], load_req};
      step_hist_reg <= step_sync_reg[SYNC_STAGES-1];
      load_hist_reg <= load_sync_reg[SYNC_STAGES-1];
    end
  end

  assign run_synced = run_sync_reg[SYNC_STAGES-1];
  assign step_evt   = step_sync_reg[SYNC_STAGES-1] & ~step_hist_reg;
  assign load_evt   = load_sync_reg[SYNC_STAGES-1] & ~load_hist_reg;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= PAUSED;
    end else begin
      state_reg <= state_next;
    end
  end

  // Mode next-state: simply follows the synchronized run level.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PAUSED:  if (run_synced)  state_next = RUNNING;
      RUNNING: if (!run_synced) state_next = PAUSED;
      default: state_next = PAUSED;
    endcase
  end

  // Prescaler, advance source selection and digit arithmetic.
  // A load wins over a same-cycle advance, and that advance is lost.
  always_comb begin
    presc_next = presc_reg;
    digit_next = digit_reg;
    tick_next  = 1'b0;
    wrap_next  = 1'b0;
    advance    = 1'b0;

    if (state_reg == RUNNING) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        advance    = 1'b1;
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end else begin
      presc_next = '0;
      if (step_evt) begin
        advance = 1'b1;
      end
    end

    if (load_evt) begin
      presc_next = '0;
      digit_next = (load_val > DIGIT_TOP) ? DIGIT_TOP : load_val;
    end else if (advance) begin
      tick_next = 1'b1;
      if (!dir) begin
        if (digit_reg >= DIGIT_TOP) begin
          digit_next = 4'd0;
          wrap_next  = 1'b1;
        end else begin
          digit_next = digit_reg + 4'd1;
        end
      end else begin
        if (digit_reg == 4'd0) begin
          digit_next = DIGIT_TOP;
          wrap_next  = 1'b1;
        end else begin
          digit_next = digit_reg - 4'd1;
        end
      end
    end
  end

  // Datapath registers; tick/wrap are registered alongside the digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
      digit_reg <= 4'd0;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      digit_reg <= digit_next;
      tick_reg  <= tick_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign digit   = digit_reg;
  assign tick    = tick_reg;
  assign wrap    = wrap_reg;
  assign running = (state_reg == RUNNING);

endmodule
